// File: rtl/vga_pkg.sv
// vga_pkg: VESA 800x600@60 timing constants and vblank scheduler state encoding.
package vga_pkg;
  localparam int H_ACTIVE   = 800;
  localparam int H_TOTAL    = 1056;
  localparam int H_SYNC_ST  = 840;
  localparam int H_SYNC_LEN = 128;
  localparam int V_ACTIVE   = 600;
  localparam int V_TOTAL    = 628;
  localparam int V_SYNC_ST  = 601;
  localparam int V_SYNC_LEN = 4;
  localparam int VBLANK_CYC = (V_TOTAL - V_ACTIVE) * H_TOTAL;
  typedef enum logic [1:0] {IDLE, ARB, GRANT} sched_state_e;
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/vga_vblank_scheduler_if.sv
// vga_vblank_scheduler_if: agent request/done and scheduler grant/status bundle.
interface vga_vblank_scheduler_if #(parameter int N_REQ = 4) ();
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] done;
  logic [N_REQ-1:0] grant;
  logic             window;
  logic             frame_tick;
  logic             timeout;
  logic             overrun;
  logic [7:0]       overrun_cnt;
  modport master (output req, done, input grant, window, frame_tick, timeout, overrun, overrun_cnt);
  modport slave  (input req, done, output grant, window, frame_tick, timeout, overrun, overrun_cnt);
endinterface

// File: rtl/vga_vblank_scheduler_rr_arbiter.sv
// vga_vblank_scheduler_rr_arbiter: combinational round-robin pick starting at ptr_i.
module vga_vblank_scheduler_rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          valid_o
);
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    // Walk offsets high to low so the smallest offset from ptr_i wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_i) + k) % N]) begin
        idx_o   = PW'((int'(ptr_i) + k) % N);
        valid_o = 1'b1;
      end
    end
    gnt_o = valid_o ? (N'(1) << idx_o) : '0;
  end
endmodule

// File: rtl/vga_vblank_scheduler.sv
// vga_vblank_scheduler: round-robin, timeout-bounded sharing of the vblank window among agents.
module vga_vblank_scheduler
  import vga_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int MAX_GRANT = 4096,
  parameter int CNT_W     = 13
) (
  input  logic                  pclk,
  input  logic                  rst_n,
  input  logic                  vblnk,
  vga_vblank_scheduler_if.slave bus
);
  localparam int PW = $clog2(N_REQ);
  sched_state_e     state_q;
  logic             vblnk_q, window_q, frame_tick_q, timeout_q, overrun_q;
  logic [N_REQ-1:0] grant_q, arb_gnt;
  logic [PW-1:0]    rr_ptr_q, cur_q, rr_ptr_d, arb_idx;
  logic [CNT_W-1:0] tmo_q;
  logic [7:0]       overrun_cnt_q;
  logic             rise, fall, rel_done, tmo_hit, arb_valid;

  vga_vblank_scheduler_rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb (
    .req_i(bus.req), .ptr_i(rr_ptr_q), .gnt_o(arb_gnt), .idx_o(arb_idx), .valid_o(arb_valid)
  );

  assign rise     = vblnk & ~vblnk_q;
  assign fall     = ~vblnk & vblnk_q;
  // A withdrawn request releases the grant exactly like a done pulse.
  assign rel_done = |(bus.done & grant_q) | ~|(bus.req & grant_q);
  assign tmo_hit  = tmo_q == CNT_W'(MAX_GRANT - 1);
  assign rr_ptr_d = (cur_q == PW'(N_REQ - 1)) ? '0 : cur_q + 1'b1;

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      vblnk_q       <= 1'b0;
      grant_q       <= '0;
      cur_q         <= '0;
      rr_ptr_q      <= '0;
      tmo_q         <= '0;
      window_q      <= 1'b0;
      frame_tick_q  <= 1'b0;
      timeout_q     <= 1'b0;
      overrun_q     <= 1'b0;
      overrun_cnt_q <= '0;
    end else begin
      vblnk_q      <= vblnk;
      frame_tick_q <= 1'b0;
      timeout_q    <= 1'b0;
      overrun_q    <= 1'b0;
      if (fall) begin
        state_q  <= IDLE;
        window_q <= 1'b0;
        grant_q  <= '0;
        if (|grant_q) begin
          rr_ptr_q <= rr_ptr_d;
          if (!rel_done) begin
            overrun_q     <= 1'b1;
            overrun_cnt_q <= sat_inc(overrun_cnt_q);
          end
        end
      end else begin
        case (state_q)
          IDLE: if (rise) begin
            state_q      <= ARB;
            window_q     <= 1'b1;
            frame_tick_q <= 1'b1;
          end
          ARB: if (arb_valid) begin
            state_q <= GRANT;
            grant_q <= arb_gnt;
            cur_q   <= arb_idx;
            tmo_q   <= '0;
          end
          GRANT: begin
            tmo_q <= tmo_q + 1'b1;
            if (rel_done || tmo_hit) begin
              state_q  <= ARB;
              grant_q  <= '0;
              rr_ptr_q <= rr_ptr_d;
              if (!rel_done) begin
                timeout_q     <= 1'b1;
                overrun_cnt_q <= sat_inc(overrun_cnt_q);
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.grant       = grant_q;
  assign bus.window      = window_q;
  assign bus.frame_tick  = frame_tick_q;
  assign bus.timeout     = timeout_q;
  assign bus.overrun     = overrun_q;
  assign bus.overrun_cnt = overrun_cnt_q;
endmodule
